// File: rtl/ex_issue_if.sv
// Decode-side and ALU-side handshake bundle for the execute issue stage.
// The slave modport is the issue stage itself; master is whatever surrounds it.
interface ex_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_use_pc;
    logic        in_use_imm;
    logic        in_wb_en;
    logic        in_is_load;
    logic [4:0]  in_op;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_c;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_is_load;

    modport master (
        output in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm,
               in_rs1, in_rs2, in_rd, in_use_pc, in_use_imm,
               in_wb_en, in_is_load, in_op,
        input  in_ready,
        input  out_valid, alu_a, alu_b, alu_c, out_rd, out_wb_en, out_is_load,
        output out_ready
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm,
               in_rs1, in_rs2, in_rd, in_use_pc, in_use_imm,
               in_wb_en, in_is_load, in_op,
        output in_ready,
        output out_valid, alu_a, alu_b, alu_c, out_rd, out_wb_en, out_is_load,
        input  out_ready
    );
endinterface

// File: rtl/ex_issue.sv
// Single-entry execute issue register with operand forwarding and load-use stall.
// Define EX_ISSUE_STATS_EN to add the stall_cnt / issue_cnt statistics outputs.
module ex_issue (
    input  logic        clk,
    input  logic        rst,
    ex_issue_if.slave   bus,
    input  logic [4:0]  fwd_mem_rd,
    input  logic        fwd_mem_wb_en,
    input  logic        fwd_mem_is_load,
    input  logic [31:0] fwd_mem_val,
    input  logic [4:0]  fwd_wb_rd,
    input  logic        fwd_wb_en,
    input  logic [31:0] fwd_wb_val,
    input  logic        flush
`ifdef EX_ISSUE_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] issue_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state;
    state_t      eff_state;

    logic [31:0] h_pc;
    logic [31:0] h_rs1_val;
    logic [31:0] h_rs2_val;
    logic [31:0] h_imm;
    logic [4:0]  h_rs1;
    logic [4:0]  h_rs2;
    logic [4:0]  h_rd;
    logic        h_use_pc;
    logic        h_use_imm;
    logic        h_wb_en;
    logic        h_is_load;
    logic [4:0]  h_op;

    logic        held;
    logic        hazard;
    logic        capture;
    logic        drain;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    // x0 is hardwired, so its stored value passes through untouched; a load in
    // EX/MEM has no data yet and is never a forwarding source.
    function automatic logic [31:0] fwd_select(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic [4:0]  m_rd,
        input logic        m_en,
        input logic        m_ld,
        input logic [31:0] m_val,
        input logic [4:0]  w_rd,
        input logic        w_en,
        input logic [31:0] w_val
    );
        logic [31:0] r;
        r = stored;
        if (addr != 5'd0) begin
            if (m_en && !m_ld && (m_rd == addr))
                r = m_val;
            else if (w_en && (w_rd == addr))
                r = w_val;
        end
        return r;
    endfunction

    function automatic logic [31:0] wb_bypass(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic [4:0]  w_rd,
        input logic        w_en,
        input logic [31:0] w_val
    );
        logic [31:0] r;
        r = stored;
        if (w_en && (w_rd != 5'd0) && (w_rd == addr))
            r = w_val;
        return r;
    endfunction

    // The stall is judged against the entry already held, so out_valid drops in
    // the very cycle the producing load sits in EX/MEM.
    always_comb begin
        held   = (state != EMPTY);
        hazard = held && fwd_mem_wb_en && fwd_mem_is_load && (fwd_mem_rd != 5'd0) &&
                 ((!h_use_pc  && (h_rs1 == fwd_mem_rd)) ||
                  (!h_use_imm && (h_rs2 == fwd_mem_rd)));
        if (!held)
            eff_state = EMPTY;
        else if (hazard)
            eff_state = STALL;
        else
            eff_state = FULL;
    end

    always_comb begin
        rs1_fwd = fwd_select(h_rs1, h_rs1_val, fwd_mem_rd, fwd_mem_wb_en, fwd_mem_is_load,
                             fwd_mem_val, fwd_wb_rd, fwd_wb_en, fwd_wb_val);
        rs2_fwd = fwd_select(h_rs2, h_rs2_val, fwd_mem_rd, fwd_mem_wb_en, fwd_mem_is_load,
                             fwd_mem_val, fwd_wb_rd, fwd_wb_en, fwd_wb_val);
    end

    assign bus.in_ready    = (eff_state == EMPTY) || ((eff_state == FULL) && bus.out_ready);
    assign bus.out_valid   = (eff_state == FULL);
    assign bus.alu_a       = h_use_pc  ? h_pc  : rs1_fwd;
    assign bus.alu_b       = h_use_imm ? h_imm : rs2_fwd;
    assign bus.alu_c       = h_op;
    assign bus.out_rd      = h_rd;
    assign bus.out_wb_en   = h_wb_en;
    assign bus.out_is_load = h_is_load;

    assign capture = bus.in_valid && bus.in_ready && !flush;
    assign drain   = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            h_pc      <= '0;
            h_rs1_val <= '0;
            h_rs2_val <= '0;
            h_imm     <= '0;
            h_rs1     <= '0;
            h_rs2     <= '0;
            h_rd      <= '0;
            h_use_pc  <= 1'b0;
            h_use_imm <= 1'b0;
            h_wb_en   <= 1'b0;
            h_is_load <= 1'b0;
            h_op      <= '0;
        end else begin
            if (flush)
                state <= EMPTY;
            else if (capture)
                state <= FULL;
            else if (drain)
                state <= EMPTY;
            else
                state <= eff_state;

            if (capture) begin
                h_pc      <= bus.in_pc;
                h_rs1_val <= wb_bypass(bus.in_rs1, bus.in_rs1_val, fwd_wb_rd, fwd_wb_en, fwd_wb_val);
                h_rs2_val <= wb_bypass(bus.in_rs2, bus.in_rs2_val, fwd_wb_rd, fwd_wb_en, fwd_wb_val);
                h_imm     <= bus.in_imm;
                h_rs1     <= bus.in_rs1;
                h_rs2     <= bus.in_rs2;
                h_rd      <= bus.in_rd;
                h_use_pc  <= bus.in_use_pc;
                h_use_imm <= bus.in_use_imm;
                h_wb_en   <= bus.in_wb_en;
                h_is_load <= bus.in_is_load;
                h_op      <= bus.in_op;
            end else if (held) begin
                // A register write-back would otherwise be lost once it leaves WB.
                h_rs1_val <= wb_bypass(h_rs1, h_rs1_val, fwd_wb_rd, fwd_wb_en, fwd_wb_val);
                h_rs2_val <= wb_bypass(h_rs2, h_rs2_val, fwd_wb_rd, fwd_wb_en, fwd_wb_val);
            end
        end
    end

`ifdef EX_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (eff_state == STALL)
                stall_cnt <= stall_cnt + 32'd1;
            if (drain)
                issue_cnt <= issue_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_issue.sv
// Directed self-checking bench for ex_issue; define EX_ISSUE_STATS_EN to also
// exercise the statistics counters.
module tb_ex_issue;

    logic        clk;
    logic        rst;
    logic [4:0]  fwd_mem_rd;
    logic        fwd_mem_wb_en;
    logic        fwd_mem_is_load;
    logic [31:0] fwd_mem_val;
    logic [4:0]  fwd_wb_rd;
    logic        fwd_wb_en;
    logic [31:0] fwd_wb_val;
    logic        flush;
`ifdef EX_ISSUE_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] issue_cnt;
`endif

    int checks = 0;
    int errors = 0;

    ex_issue_if bus ();

    ex_issue dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .fwd_mem_rd      (fwd_mem_rd),
        .fwd_mem_wb_en   (fwd_mem_wb_en),
        .fwd_mem_is_load (fwd_mem_is_load),
        .fwd_mem_val     (fwd_mem_val),
        .fwd_wb_rd       (fwd_wb_rd),
        .fwd_wb_en       (fwd_wb_en),
        .fwd_wb_val      (fwd_wb_val),
        .flush           (flush)
`ifdef EX_ISSUE_STATS_EN
        ,
        .stall_cnt       (stall_cnt),
        .issue_cnt       (issue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_in(input logic v, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [31:0] rs1_val,
                            input logic [4:0] rs2, input logic [31:0] rs2_val,
                            input logic [31:0] imm, input logic [4:0] rd,
                            input logic use_pc, input logic use_imm,
                            input logic is_load, input logic [4:0] op);
        bus.in_valid   = v;
        bus.in_pc      = pc;
        bus.in_rs1     = rs1;
        bus.in_rs1_val = rs1_val;
        bus.in_rs2     = rs2;
        bus.in_rs2_val = rs2_val;
        bus.in_imm     = imm;
        bus.in_rd      = rd;
        bus.in_use_pc  = use_pc;
        bus.in_use_imm = use_imm;
        bus.in_wb_en   = 1'b1;
        bus.in_is_load = is_load;
        bus.in_op      = op;
    endtask

    task automatic clear_fwd();
        fwd_mem_rd      = 5'd0;
        fwd_mem_wb_en   = 1'b0;
        fwd_mem_is_load = 1'b0;
        fwd_mem_val     = 32'd0;
        fwd_wb_rd       = 5'd0;
        fwd_wb_en       = 1'b0;
        fwd_wb_val      = 32'd0;
    endtask

    // Captures one entry from an empty stage; returns just after a falling edge.
    task automatic load_entry(input logic [31:0] pc,
                              input logic [4:0] rs1, input logic [31:0] rs1_val,
                              input logic [4:0] rs2, input logic [31:0] rs2_val,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic use_pc, input logic use_imm,
                              input logic is_load, input logic [4:0] op);
        @(negedge clk);
        drive_in(1'b1, pc, rs1, rs1_val, rs2, rs2_val, imm, rd, use_pc, use_imm, is_load, op);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        clear_fwd();
        drive_in(1'b0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_alu_a: got %h expected 0", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_alu_b: got %h expected 0", bus.alu_b); end
        checks++; if (bus.alu_c !== 5'd0) begin errors++; $display("[TB] FAIL reset_alu_c: got %h expected 0", bus.alu_c); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_capture();
        load_entry(32'h100, 5'd1, 32'h10, 5'd2, 32'h20, 32'h5, 5'd4, 1'b0, 1'b0, 1'b0, 5'd3);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL cap_out_valid: got %0b expected 1", bus.out_valid); end
        checks++; if (bus.alu_a !== 32'h10) begin errors++; $display("[TB] FAIL cap_alu_a: got %h expected 10", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'h20) begin errors++; $display("[TB] FAIL cap_alu_b: got %h expected 20", bus.alu_b); end
        checks++; if (bus.alu_c !== 5'd3) begin errors++; $display("[TB] FAIL cap_alu_c: got %h expected 3", bus.alu_c); end
        checks++; if (bus.out_rd !== 5'd4 || bus.out_wb_en !== 1'b1 || bus.out_is_load !== 1'b0) begin
            errors++; $display("[TB] FAIL cap_sideband: got rd=%0d wb=%0b ld=%0b expected rd=4 wb=1 ld=0", bus.out_rd, bus.out_wb_en, bus.out_is_load);
        end
        drive_in(1'b1, 32'h200, 5'd3, 32'h30, 5'd4, 32'h40, 32'h7, 5'd9, 1'b1, 1'b1, 1'b1, 5'h1F);
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %0b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd9 || bus.out_is_load !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_entry: got v=%0b rd=%0d ld=%0b expected v=1 rd=9 ld=1", bus.out_valid, bus.out_rd, bus.out_is_load);
        end
        checks++; if (bus.alu_a !== 32'h200) begin errors++; $display("[TB] FAIL use_pc_alu_a: got %h expected 200", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'h7) begin errors++; $display("[TB] FAIL use_imm_alu_b: got %h expected 7", bus.alu_b); end
        checks++; if (bus.alu_c !== 5'h1F) begin errors++; $display("[TB] FAIL b2b_alu_c: got %h expected 1f", bus.alu_c); end
        drain_all();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        load_entry(32'h0, 5'd1, 32'hA1, 5'd0, 32'd0, 32'h1, 5'd3, 1'b0, 1'b1, 1'b0, 5'd1);
        drive_in(1'b1, 32'h0, 5'd2, 32'hB2, 5'd0, 32'd0, 32'h2, 5'd6, 1'b0, 1'b1, 1'b0, 5'd2);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %0b expected 0", i, bus.in_ready); end
            checks++; if (bus.out_rd !== 5'd3 || bus.alu_a !== 32'hA1) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got rd=%0d a=%h expected rd=3 a=a1", i, bus.out_rd, bus.alu_a);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_ready: got %0b expected 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd6 || bus.alu_a !== 32'hB2 || bus.alu_c !== 5'd2) begin
            errors++; $display("[TB] FAIL bp_new_entry: got v=%0b rd=%0d a=%h c=%0d expected v=1 rd=6 a=b2 c=2",
                               bus.out_valid, bus.out_rd, bus.alu_a, bus.alu_c);
        end
        drain_all();
    endtask

    task automatic test_forward();
        load_entry(32'h0, 5'd5, 32'h55, 5'd0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1, 1'b0, 5'd4);
        fwd_mem_rd = 5'd5; fwd_mem_wb_en = 1'b1; fwd_mem_is_load = 1'b0; fwd_mem_val = 32'h11;
        fwd_wb_rd = 5'd5; fwd_wb_en = 1'b1; fwd_wb_val = 32'h22;
        #1;
        checks++; if (bus.alu_a !== 32'h11) begin errors++; $display("[TB] FAIL fwd_mem_prio: got %h expected 11", bus.alu_a); end
        fwd_mem_wb_en = 1'b0;
        #1;
        checks++; if (bus.alu_a !== 32'h22) begin errors++; $display("[TB] FAIL fwd_wb: got %h expected 22", bus.alu_a); end
        @(negedge clk);
        fwd_wb_en = 1'b0;
        #1;
        checks++; if (bus.alu_a !== 32'h22) begin errors++; $display("[TB] FAIL fwd_retention: got %h expected 22", bus.alu_a); end
        fwd_mem_wb_en = 1'b1; fwd_mem_is_load = 1'b1; fwd_mem_val = 32'h33;
        #1;
        checks++; if (bus.alu_a !== 32'h22 || bus.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL fwd_no_load_src: got a=%h v=%0b expected a=22 v=0", bus.alu_a, bus.out_valid);
        end
        clear_fwd();
        @(negedge clk);
        drain_all();
        load_entry(32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0, 5'd5);
        fwd_mem_rd = 5'd0; fwd_mem_wb_en = 1'b1; fwd_mem_is_load = 1'b0; fwd_mem_val = 32'h11;
        fwd_wb_rd = 5'd0; fwd_wb_en = 1'b1; fwd_wb_val = 32'h22;
        #1;
        checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
            errors++; $display("[TB] FAIL fwd_x0: got a=%h b=%h expected 0 0", bus.alu_a, bus.alu_b);
        end
        fwd_mem_is_load = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL x0_no_hazard: got %0b expected 1", bus.out_valid); end
        clear_fwd();
        drain_all();
    endtask

    task automatic test_capture_bypass();
        @(negedge clk);
        drive_in(1'b1, 32'h44, 5'd0, 32'd0, 5'd9, 32'h99, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd7);
        fwd_wb_rd = 5'd9; fwd_wb_en = 1'b1; fwd_wb_val = 32'h77;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        clear_fwd();
        #1;
        checks++; if (bus.alu_b !== 32'h77) begin errors++; $display("[TB] FAIL cap_bypass_alu_b: got %h expected 77", bus.alu_b); end
        checks++; if (bus.alu_a !== 32'h44) begin errors++; $display("[TB] FAIL cap_bypass_alu_a: got %h expected 44", bus.alu_a); end
        drain_all();
    endtask

    task automatic test_load_use();
        load_entry(32'h300, 5'd1, 32'h10, 5'd7, 32'h70, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 5'd6);
        fwd_mem_rd = 5'd7; fwd_mem_wb_en = 1'b1; fwd_mem_is_load = 1'b1; fwd_mem_val = 32'hDEAD;
        bus.out_ready = 1'b1;
        drive_in(1'b1, 32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd12, 1'b0, 1'b0, 1'b0, 5'd9);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_out_valid: got %0b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL lu_in_ready: got %0b expected 0", bus.in_ready); end
        @(negedge clk);
        clear_fwd();
        fwd_wb_rd = 5'd7; fwd_wb_en = 1'b1; fwd_wb_val = 32'hABCD;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.alu_b !== 32'hABCD) begin errors++; $display("[TB] FAIL lu_wb_fwd: got %h expected abcd", bus.alu_b); end
        @(negedge clk);
        fwd_wb_en = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.alu_b !== 32'hABCD) begin
            errors++; $display("[TB] FAIL lu_resume: got v=%0b b=%h expected v=1 b=abcd", bus.out_valid, bus.alu_b);
        end
        checks++; if (bus.out_rd !== 5'd8 || bus.alu_a !== 32'h300) begin
            errors++; $display("[TB] FAIL lu_no_overwrite: got rd=%0d a=%h expected rd=8 a=300", bus.out_rd, bus.alu_a);
        end
    endtask

    task automatic test_flush();
        drive_in(1'b1, 32'h0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd13, 1'b0, 1'b0, 1'b0, 5'd1);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %0b expected 1", bus.in_ready); end
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_empty: got v=%0b r=%0b expected v=0 r=1", bus.out_valid, bus.in_ready);
        end
        load_entry(32'h0, 5'd1, 32'h1, 5'd2, 32'h2, 32'd0, 5'd14, 1'b0, 1'b0, 1'b0, 5'd2);
        flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_full_in_ready: got %0b expected 0", bus.in_ready); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_held: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        load_entry(32'h500, 5'd3, 32'h3, 5'd4, 32'h4, 32'd0, 5'd15, 1'b1, 1'b0, 1'b0, 5'd3);
        drive_in(1'b1, 32'h600, 5'd3, 32'h3, 5'd4, 32'h4, 32'd0, 5'd16, 1'b1, 1'b0, 1'b0, 5'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid: got v=%0b r=%0b expected v=0 r=1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.alu_a !== 32'd0 || bus.out_rd !== 5'd0) begin
            errors++; $display("[TB] FAIL rst_mid_data: got a=%h rd=%0d expected 0 0", bus.alu_a, bus.out_rd);
        end
    endtask

`ifdef EX_ISSUE_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (stall_cnt !== 32'd0 || issue_cnt !== 32'd0) begin
            errors++; $display("[TB] FAIL stats_reset: got s=%0d i=%0d expected 0 0", stall_cnt, issue_cnt);
        end
        load_entry(32'h0, 5'd0, 32'd0, 5'd7, 32'h7, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd1);
        fwd_mem_rd = 5'd7; fwd_mem_wb_en = 1'b1; fwd_mem_is_load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear_fwd();
        drain_all();
        for (int i = 0; i < 2; i++) begin
            load_entry(32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd1);
            drain_all();
        end
        #1;
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("[TB] FAIL stats_stall: got %0d expected 2", stall_cnt); end
        checks++; if (issue_cnt !== 32'd3) begin errors++; $display("[TB] FAIL stats_issue: got %0d expected 3", issue_cnt); end
        dut.issue_cnt = 32'hFFFF_FFFF;
        load_entry(32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd1);
        drain_all();
        #1;
        checks++; if (issue_cnt !== 32'd0) begin errors++; $display("[TB] FAIL stats_wrap: got %h expected 0", issue_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_back_to_back();
        test_forward();
        test_capture_bypass();
        test_load_use();
        test_flush();
        test_reset_mid();
`ifdef EX_ISSUE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
